// File: rtl/psram_responder.sv
// Clocked stand-in for the async CellularRAM: samples the controller's strobes,
// commits byte-masked writes into a block-RAM array and returns reads after a fixed latency.
//
// state      | meaning
// IDLE       | bus idle, waiting for CE# and ADV# low
// ADDR       | address phase, waiting for ADV# to rise
// WRITE      | write data phase, commit on WE# or CE# rising
// READ_WAIT  | counting access latency, waiting for OE# low
// READ_DRIVE | driving read data until OE# or CE# rises

module psram_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int ACCESS_CYCLES = 8,
    parameter int BANK          = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  cram_a,
    input  logic [15:0] cram_dq_in,
    output logic [15:0] cram_dq_out,
    output logic        cram_dq_oe,
    input  logic        cram_adv_n,
    input  logic        cram_ce0_n,
    input  logic        cram_ce1_n,
    input  logic        cram_oe_n,
    input  logic        cram_we_n,
    input  logic        cram_ub_n,
    input  logic        cram_lb_n,
    output logic        cram_wait,
    output logic        protocol_error,
    output logic [15:0] write_count,
    output logic [15:0] read_count
);

    typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ_WAIT, READ_DRIVE} state_t;

    // s_* lags the pins by one edge, so the latency compare runs one count early.
    localparam logic [3:0] DRIVE_AT = 4'(ACCESS_CYCLES - 2);

    logic        ce_sel;
    logic [5:0]  s_a_q, p_a_q;
    logic [15:0] s_dq_q, p_dq_q;
    logic        s_adv_n_q, s_ce_n_q, s_oe_n_q, s_we_n_q, s_ub_n_q, s_lb_n_q;
    logic        p_adv_n_q, p_ce_n_q, p_we_n_q, p_ub_n_q, p_lb_n_q;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic [21:0] addr_q, addr_d;
    logic        dq_oe_q, dq_oe_d;
    logic        err_q, err_d;
    logic [15:0] dq_out_q;
    logic [15:0] wcnt_q, rcnt_q;
    logic        commit, rd_load, rd_done;
    logic [15:0] mem_q [2**ADDR_WIDTH];

    // Latched address bits above the array width alias and are deliberately dropped.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr_q;

    assign ce_sel = (BANK == 0) ? cram_ce0_n : cram_ce1_n;
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dq_oe_d = dq_oe_q;
        commit  = 1'b0;
        rd_load = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s_ce_n_q && !s_adv_n_q) begin
                    state_d = ADDR;
                    cnt_d   = 4'd1;
                end
            end
            ADDR: begin
                cnt_d = cnt_inc;
                if (s_ce_n_q) begin
                    state_d = IDLE;
                end else if (s_adv_n_q && !p_adv_n_q) begin
                    addr_d  = {p_a_q, p_dq_q};
                    state_d = p_we_n_q ? READ_WAIT : WRITE;
                end
            end
            WRITE: begin
                if ((s_we_n_q && !p_we_n_q) || (s_ce_n_q && !p_ce_n_q)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (s_ce_n_q) begin
                    state_d = IDLE;
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_inc;
                if (s_ce_n_q) begin
                    state_d = IDLE;
                end else if (cnt_q >= DRIVE_AT && !s_oe_n_q) begin
                    rd_load = 1'b1;
                    dq_oe_d = 1'b1;
                    state_d = READ_DRIVE;
                end
            end
            READ_DRIVE: begin
                if (s_oe_n_q || s_ce_n_q) begin
                    dq_oe_d = 1'b0;
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (!s_oe_n_q && !s_we_n_q) || (!s_adv_n_q && s_ce_n_q) ||
                (!s_oe_n_q && state_q == ADDR) || (dq_oe_q && !s_we_n_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_a_q     <= '0;  p_a_q    <= '0;
            s_dq_q    <= '0;  p_dq_q   <= '0;
            s_adv_n_q <= 1'b1; s_ce_n_q <= 1'b1; s_oe_n_q <= 1'b1;
            s_we_n_q  <= 1'b1; s_ub_n_q <= 1'b1; s_lb_n_q <= 1'b1;
            p_adv_n_q <= 1'b1; p_ce_n_q <= 1'b1; p_we_n_q <= 1'b1;
            p_ub_n_q  <= 1'b1; p_lb_n_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= '0;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            s_a_q     <= cram_a;      p_a_q    <= s_a_q;
            s_dq_q    <= cram_dq_in;  p_dq_q   <= s_dq_q;
            s_adv_n_q <= cram_adv_n;  p_adv_n_q <= s_adv_n_q;
            s_ce_n_q  <= ce_sel;      p_ce_n_q <= s_ce_n_q;
            s_oe_n_q  <= cram_oe_n;
            s_we_n_q  <= cram_we_n;   p_we_n_q <= s_we_n_q;
            s_ub_n_q  <= cram_ub_n;   p_ub_n_q <= s_ub_n_q;
            s_lb_n_q  <= cram_lb_n;   p_lb_n_q <= s_lb_n_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dq_oe_q   <= dq_oe_d;
            err_q     <= err_d;
            if (rd_load) begin
                dq_out_q[15:8] <= s_ub_n_q ? 8'h00 : mem_q[addr_q[ADDR_WIDTH-1:0]][15:8];
                dq_out_q[7:0]  <= s_lb_n_q ? 8'h00 : mem_q[addr_q[ADDR_WIDTH-1:0]][7:0];
            end
            if (commit)  wcnt_q <= wcnt_q + 16'd1;
            if (rd_done) rcnt_q <= rcnt_q + 16'd1;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && !reset) begin
            if (!p_ub_n_q) mem_q[addr_q[ADDR_WIDTH-1:0]][15:8] <= p_dq_q[15:8];
            if (!p_lb_n_q) mem_q[addr_q[ADDR_WIDTH-1:0]][7:0]  <= p_dq_q[7:0];
        end
    end

    assign cram_dq_out    = dq_out_q;
    assign cram_dq_oe     = dq_oe_q;
    assign cram_wait      = 1'b0;
    assign protocol_error = err_q;
    assign write_count    = wcnt_q;
    assign read_count     = rcnt_q;

endmodule
